// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush/forward controller for the classic 5-stage pipeline.
// Handles data-memory stalls, HALT, redirects, load-use hazards and
// instruction-fetch misses. It drives the PC enable, the four latch
// enables and flushes, and the EX-stage forwarding selects.
// Optional build macro: HAZARD_STALL_CNT_EN adds saturating stall
// counters (cnt_mem, cnt_lu, cnt_if) of width CNT_W.
module pipeline_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int BRANCH_STAGE = 1,
  parameter int CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_wsel,
  input  logic              ex_regwen,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_wsel,
  input  logic              mem_regwen,
  input  logic              mem_dmemop,
  input  logic              mem_halt,
  input  logic [REG_AW-1:0] wb_wsel,
  input  logic              wb_regwen,
  input  logic              redirect,
  output logic              pc_en,
  output logic              imemREN,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              exmem_flush,
  output logic              memwb_en,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              halt,
  output logic [1:0]        state
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_mem,
  output logic [CNT_W-1:0]  cnt_lu,
  output logic [CNT_W-1:0]  cnt_if
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DWAIT  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  // Which hazard rule governs the current cycle, highest priority first.
  typedef enum logic [2:0] {
    R_MSTALL,
    R_HALT,
    R_REDIRECT,
    R_LOADUSE,
    R_IMISS,
    R_NONE
  } rule_t;

  state_t cur_state;
  state_t nxt_state;
  rule_t  rule;

  logic mstall;
  logic load_use;
  logic lu_rs_match;
  logic lu_rt_match;

  assign state = cur_state;

  // Only a real load to a non-zero register can create a load-use bubble.
  assign mstall      = mem_dmemop & ~dhit;
  assign lu_rs_match = id_uses_rs & (id_rs == ex_wsel);
  assign lu_rt_match = id_uses_rt & (id_rt == ex_wsel);
  assign load_use    = ex_memread & ex_regwen & (ex_wsel != '0) &
                       (lu_rs_match | lu_rt_match);

  // Forwarding select: the younger MEM result beats the older WB result.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] m_wsel,
    input logic              m_wen,
    input logic [REG_AW-1:0] w_wsel,
    input logic              w_wen
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (m_wen && (m_wsel != '0) && (m_wsel == src)) begin
      sel = 2'b01;
    end else if (w_wen && (w_wsel != '0) && (w_wsel == src)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  // Forwarding stays active in every state, including HALTED.
  always_comb begin
    fwd_a = fwd_sel(ex_rs, mem_wsel, mem_regwen, wb_wsel, wb_regwen);
    fwd_b = fwd_sel(ex_rt, mem_wsel, mem_regwen, wb_wsel, wb_regwen);
  end

  // Pick the single governing hazard rule by priority.
  always_comb begin
    rule = R_NONE;
    if (mstall) begin
      rule = R_MSTALL;
    end else if (mem_halt) begin
      rule = R_HALT;
    end else if (redirect) begin
      rule = R_REDIRECT;
    end else if (load_use) begin
      rule = R_LOADUSE;
    end else if (!ihit) begin
      rule = R_IMISS;
    end
  end

  // State register; reset forces RUN immediately, even mid-stall or halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cur_state <= ST_RUN;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Sticky halt flag, set as the FSM enters HALTED and cleared only by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halt <= 1'b0;
    end else if (nxt_state == ST_HALTED) begin
      halt <= 1'b1;
    end
  end

  // Next-state and latch control; a flushed latch also keeps its enable high.
  always_comb begin
    nxt_state   = ST_RUN;
    pc_en       = 1'b1;
    imemREN     = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    if (cur_state == ST_HALTED) begin
      nxt_state = ST_HALTED;
      pc_en     = 1'b0;
      imemREN   = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
    end else begin
      unique case (rule)
        R_MSTALL: begin
          nxt_state = ST_DWAIT;
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          exmem_en  = 1'b0;
          memwb_en  = 1'b0;
        end
        R_HALT: begin
          nxt_state   = ST_HALTED;
          pc_en       = 1'b0;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end
        R_REDIRECT: begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = (BRANCH_STAGE == 2);
        end
        R_LOADUSE: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
        R_IMISS: begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  // Saturating stall counters; they stop counting once the pipe is halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_mem <= '0;
      cnt_lu  <= '0;
      cnt_if  <= '0;
    end else if (cur_state != ST_HALTED) begin
      if ((rule == R_MSTALL) && (cnt_mem != '1)) begin
        cnt_mem <= cnt_mem + 1'b1;
      end
      if ((rule == R_LOADUSE) && (cnt_lu != '1)) begin
        cnt_lu <= cnt_lu + 1'b1;
      end
      if ((rule == R_IMISS) && (cnt_if != '1)) begin
        cnt_if <= cnt_if + 1'b1;
      end
    end
  end
`else
  logic cnt_w_unused;
  assign cnt_w_unused = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Self-checking bench for pipeline_hazard_ctrl. Two instances share every
// input, one resolving redirects in EX and one in MEM. Expected values come
// from a rule-table model kept in the bench.
// Honours HAZARD_STALL_CNT_EN; when it is defined the counters use CNT_W=4.
module tb_pipeline_hazard_ctrl;

  localparam int AW = 5;
`ifdef HAZARD_STALL_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          ihit, dhit;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_wsel, mem_wsel, wb_wsel;
  logic          id_uses_rs, id_uses_rt, ex_regwen, ex_memread;
  logic          mem_regwen, mem_dmemop, mem_halt, wb_regwen, redirect;

  logic       pc_en, imemREN, ifid_en, ifid_flush, idex_en, idex_flush;
  logic       exmem_en, exmem_flush, memwb_en, halt;
  logic [1:0] fwd_a, fwd_b, state;
  logic       d2_pc_en, d2_imemREN, d2_ifid_en, d2_ifid_flush, d2_idex_en;
  logic       d2_idex_flush, d2_exmem_en, d2_exmem_flush, d2_memwb_en, d2_halt;
  logic [1:0] d2_fwd_a, d2_fwd_b, d2_state;
`ifdef HAZARD_STALL_CNT_EN
  logic [CW-1:0] cnt_mem, cnt_lu, cnt_if;
  logic [CW-1:0] d2_cnt_mem, d2_cnt_lu, d2_cnt_if;
`endif

  int cmp_count  = 0;
  int fail_count = 0;

  bit m_halted;
  bit m_wait;
  int m_cnt_mem, m_cnt_lu, m_cnt_if;

  pipeline_hazard_ctrl #(.REG_AW(AW), .BRANCH_STAGE(1), .CNT_W(CW)) dut1 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wsel(ex_wsel), .ex_regwen(ex_regwen),
    .ex_memread(ex_memread), .mem_wsel(mem_wsel), .mem_regwen(mem_regwen),
    .mem_dmemop(mem_dmemop), .mem_halt(mem_halt), .wb_wsel(wb_wsel),
    .wb_regwen(wb_regwen), .redirect(redirect),
    .pc_en(pc_en), .imemREN(imemREN), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .halt(halt), .state(state)
`ifdef HAZARD_STALL_CNT_EN
    , .cnt_mem(cnt_mem), .cnt_lu(cnt_lu), .cnt_if(cnt_if)
`endif
  );

  pipeline_hazard_ctrl #(.REG_AW(AW), .BRANCH_STAGE(2), .CNT_W(CW)) dut2 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wsel(ex_wsel), .ex_regwen(ex_regwen),
    .ex_memread(ex_memread), .mem_wsel(mem_wsel), .mem_regwen(mem_regwen),
    .mem_dmemop(mem_dmemop), .mem_halt(mem_halt), .wb_wsel(wb_wsel),
    .wb_regwen(wb_regwen), .redirect(redirect),
    .pc_en(d2_pc_en), .imemREN(d2_imemREN), .ifid_en(d2_ifid_en),
    .ifid_flush(d2_ifid_flush), .idex_en(d2_idex_en), .idex_flush(d2_idex_flush),
    .exmem_en(d2_exmem_en), .exmem_flush(d2_exmem_flush), .memwb_en(d2_memwb_en),
    .fwd_a(d2_fwd_a), .fwd_b(d2_fwd_b), .halt(d2_halt), .state(d2_state)
`ifdef HAZARD_STALL_CNT_EN
    , .cnt_mem(d2_cnt_mem), .cnt_lu(d2_cnt_lu), .cnt_if(d2_cnt_if)
`endif
  );

  // Free-running 10 ns clock.
  always #5 CLK = ~CLK;

  // Governing rule number (1..6) for the current inputs.
  function automatic int ruleOf();
    bit lu;
    lu = ex_memread && ex_regwen && (ex_wsel != 0) &&
         ((id_uses_rs && id_rs == ex_wsel) || (id_uses_rt && id_rt == ex_wsel));
    if (mem_dmemop && !dhit) return 1;
    if (mem_halt)            return 2;
    if (redirect)            return 3;
    if (lu)                  return 4;
    if (!ihit)               return 5;
    return 6;
  endfunction

  // Expected {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en}.
  function automatic logic [7:0] ctrlOf(input int rule, input int bstage);
    case (rule)
      1:       return 8'b0000_0000;
      2:       return 8'b0111_1111;
      3:       return (bstage == 2) ? 8'b1111_1111 : 8'b1111_1101;
      4:       return 8'b0001_1101;
      5:       return 8'b0111_0101;
      default: return 8'b1101_0101;
    endcase
  endfunction

  function automatic logic [1:0] fwdOf(input logic [AW-1:0] src);
    if (mem_regwen && mem_wsel != 0 && mem_wsel == src) return 2'b01;
    if (wb_regwen && wb_wsel != 0 && wb_wsel == src)    return 2'b10;
    return 2'b00;
  endfunction

  task automatic checkSig(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Idle pipeline: fetch and data accesses complete, no hazards anywhere.
  task automatic applyStimulus();
    ihit = 1'b1; dhit = 1'b1;
    id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_rs = '0; ex_rt = '0; ex_wsel = '0; ex_regwen = 1'b0; ex_memread = 1'b0;
    mem_wsel = '0; mem_regwen = 1'b0; mem_dmemop = 1'b0; mem_halt = 1'b0;
    wb_wsel = '0; wb_regwen = 1'b0; redirect = 1'b0;
  endtask

  // Compare every output shortly after the inputs settle, then advance the
  // model across the coming rising edge and wait for the next falling edge.
  task automatic checkOutput(input string tag);
    int rule;
    logic [7:0] exp1, exp2;
    #1;
    if (!nRST) begin
      m_halted = 0; m_wait = 0;
      m_cnt_mem = 0; m_cnt_lu = 0; m_cnt_if = 0;
    end
    rule = ruleOf();
    exp1 = m_halted ? 8'h00 : ctrlOf(rule, 1);
    exp2 = m_halted ? 8'h00 : ctrlOf(rule, 2);
    checkSig({tag, ".ctrl"}, 32'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                                  exmem_en, exmem_flush, memwb_en}), 32'(exp1));
    checkSig({tag, ".ctrl_bs2"}, 32'({d2_pc_en, d2_ifid_en, d2_ifid_flush, d2_idex_en,
                                      d2_idex_flush, d2_exmem_en, d2_exmem_flush,
                                      d2_memwb_en}), 32'(exp2));
    checkSig({tag, ".imemREN"}, 32'(imemREN), 32'(!m_halted));
    checkSig({tag, ".fwd_a"}, 32'(fwd_a), 32'(fwdOf(ex_rs)));
    checkSig({tag, ".fwd_b"}, 32'(fwd_b), 32'(fwdOf(ex_rt)));
    checkSig({tag, ".state"}, 32'(state), m_halted ? 32'd2 : (m_wait ? 32'd1 : 32'd0));
    checkSig({tag, ".halt"}, 32'(halt), 32'(m_halted));
    checkSig({tag, ".state_bs2"}, 32'({d2_state, d2_halt}), 32'({state, halt}));
`ifdef HAZARD_STALL_CNT_EN
    checkSig({tag, ".cnt_mem"}, 32'(cnt_mem), 32'(m_cnt_mem));
    checkSig({tag, ".cnt_lu"}, 32'(cnt_lu), 32'(m_cnt_lu));
    checkSig({tag, ".cnt_if"}, 32'(cnt_if), 32'(m_cnt_if));
`endif
    if (nRST && !m_halted) begin
      if (rule == 1 && m_cnt_mem < CNT_MAX) m_cnt_mem++;
      if (rule == 4 && m_cnt_lu < CNT_MAX)  m_cnt_lu++;
      if (rule == 5 && m_cnt_if < CNT_MAX)  m_cnt_if++;
      m_wait = (rule == 1);
      if (rule == 2) m_halted = 1;
    end
    @(negedge CLK);
  endtask

  initial begin
    $display("[TB] start");
    nRST = 1'b0;
    applyStimulus();
    @(negedge CLK);
    checkOutput("reset");
    nRST = 1'b1;
    applyStimulus();
    checkOutput("idle");

    // Load to r5 in EX while ID reads r5, then r5 moves to MEM.
    applyStimulus();
    ex_memread = 1'b1; ex_regwen = 1'b1; ex_wsel = 5'd5; id_uses_rs = 1'b1; id_rs = 5'd5;
    checkOutput("loaduse");
    applyStimulus();
    mem_regwen = 1'b1; mem_wsel = 5'd5; wb_regwen = 1'b1; wb_wsel = 5'd5; ex_rs = 5'd5;
    checkOutput("fwd_mem_wins");
    applyStimulus();
    wb_regwen = 1'b1; wb_wsel = 5'd7; ex_rt = 5'd7; mem_regwen = 1'b1; ex_rs = 5'd0;
    ex_memread = 1'b1; ex_regwen = 1'b1; ex_wsel = 5'd0; id_uses_rt = 1'b1;
    checkOutput("fwd_wb_r0");

    // Three data-memory stall cycles, then completion with a fetch miss.
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      mem_dmemop = 1'b1; dhit = 1'b0;
      checkOutput($sformatf("mstall%0d", i));
    end
    applyStimulus();
    mem_dmemop = 1'b1; ihit = 1'b0;
    checkOutput("dwait_exit");
    applyStimulus();
    checkOutput("after_dwait");

    // Redirect wins over a pending fetch.
    applyStimulus();
    redirect = 1'b1; ihit = 1'b0;
    checkOutput("redirect");

    // Random traffic with small register numbers so matches are frequent.
    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      ihit = ($urandom_range(0, 3) != 0);
      dhit = ($urandom_range(0, 2) != 0);
      id_rs = AW'($urandom_range(0, 3)); id_rt = AW'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      ex_rs = AW'($urandom_range(0, 3)); ex_rt = AW'($urandom_range(0, 3));
      ex_wsel = AW'($urandom_range(0, 3));
      ex_regwen = 1'($urandom); ex_memread = 1'($urandom);
      mem_wsel = AW'($urandom_range(0, 3)); mem_regwen = 1'($urandom);
      mem_dmemop = 1'($urandom);
      wb_wsel = AW'($urandom_range(0, 3)); wb_regwen = 1'($urandom);
      redirect = ($urandom_range(0, 4) == 0);
      checkOutput($sformatf("rand%0d", i));
    end

    // Reset asserted in the middle of a data stall.
    applyStimulus();
    mem_dmemop = 1'b1; dhit = 1'b0;
    checkOutput("pre_rst_stall0");
    checkOutput("pre_rst_stall1");
    nRST = 1'b0;
    checkOutput("rst_mid_stall");
    nRST = 1'b1;

    // Long data stall to exercise counter saturation.
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("long_stall%0d", i));
    end
`ifdef HAZARD_STALL_CNT_EN
    checkSig("cnt_mem_sat", 32'(cnt_mem), 32'(CNT_MAX));
`endif

    // HALT together with a redirect, then ten cycles of arbitrary inputs.
    applyStimulus();
    mem_halt = 1'b1; redirect = 1'b1; ihit = 1'b0;
    checkOutput("halt_entry");
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      ihit = 1'($urandom); mem_halt = 1'($urandom); redirect = 1'($urandom);
      mem_dmemop = 1'($urandom); dhit = 1'($urandom);
      ex_rs = AW'($urandom_range(0, 3)); ex_rt = AW'($urandom_range(0, 3));
      mem_wsel = AW'($urandom_range(0, 3)); mem_regwen = 1'($urandom);
      wb_wsel = AW'($urandom_range(0, 3)); wb_regwen = 1'($urandom);
      checkOutput($sformatf("halted%0d", i));
    end
    checkSig("halt_sticky", 32'(halt), 32'd1);
    nRST = 1'b0;
    applyStimulus();
    checkOutput("halt_reset");
    nRST = 1'b1;
    checkOutput("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised stall/flush/forward controller for the 5-stage pipeline. It generalises the single-cycle control decode into per-latch enable/flush control.
- Covers fetch, data-memory and load-use hazards.
- Supports a selectable branch-resolution stage.
- Latches halt as a sticky state.
- Sits beside the datapath; drives PC and all four pipeline-latch enables and flushes, plus the EX-stage operand forwarding selects.

Parameters:
REG_AW, 5, register-address width
BRANCH_STAGE, 1, stage resolving redirects: 1 = EX, 2 = MEM
CNT_W, 16, width of stall counters (optional feature only)

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
id_rs, id_rt  in  REG_AW  source regs of instruction in ID
id_uses_rs, id_uses_rt  in  1  ID instruction reads rs/rt
ex_rs, ex_rt  in  REG_AW  source regs of instruction in EX
ex_wsel  in  REG_AW  EX destination
ex_regwen, ex_memread  in  1  EX writes reg / is load
mem_wsel  in  REG_AW  MEM destination
mem_regwen  in  1  MEM writes reg
mem_dmemop  in  1  MEM holds LW or SW
mem_halt  in  1  MEM holds HALT
wb_wsel  in  REG_AW  WB destination
wb_regwen  in  1  WB writes reg
redirect  in  1  taken branch/jump/JR resolved at BRANCH_STAGE
pc_en  out  1  PC load enable
imemREN  out  1  instruction read request
ifid_en, ifid_flush  out  1  IF/ID control
idex_en, idex_flush  out  1  ID/EX control
exmem_en, exmem_flush  out  1  EX/MEM control
memwb_en  out  1  MEM/WB enable
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
halt  out  1  registered sticky halt
state  out  2  FSM state: 00 RUN, 01 DWAIT, 10 HALTED

Behaviour:
- FSM, asynchronous reset to RUN; halt resets to 0.
- Outputs other than halt and state are combinational from state and inputs.
- Flush has priority over enable at each latch.
- Priority in RUN/DWAIT, highest first:
  1. mstall = mem_dmemop & ~dhit: all *_en=0, pc_en=0, all flushes 0. Next state DWAIT.
  2. mem_halt: pc_en=0; flush IF/ID, ID/EX, EX/MEM; memwb_en=1. Next state HALTED; redirect ignored.
  3. redirect: pc_en=1 (regardless of ihit); ifid_flush=1, idex_flush=1; exmem_flush=1 only when BRANCH_STAGE==2. Other enables 1.
  4. load-use: ex_memread & ex_regwen & ex_wsel!=0 & ((id_uses_rs & id_rs==ex_wsel) | (id_uses_rt & id_rt==ex_wsel)): pc_en=0, ifid_en=0, idex_flush=1; EX/MEM and MEM/WB advance.
  5. ~ihit: pc_en=0, ifid_flush=1; downstream latches advance.
  6. Otherwise all enables 1, flushes 0.
- DWAIT returns to RUN in the cycle dhit=1. That cycle is evaluated by rules 2–6, so an instruction fetch that is still pending still produces an IF/ID bubble.
- HALTED:
  - All enables and flushes 0; pc_en=0, imemREN=0, halt=1.
  - Forwarding outputs keep their normal function.
  - Left only by nRST.
- imemREN=1 in RUN/DWAIT.
- Forwarding, fwd_a shown; fwd_b identical using ex_rt:
  - 01 if mem_regwen & mem_wsel!=0 & mem_wsel==ex_rs;
  - else 10 if wb_regwen & wb_wsel!=0 & wb_wsel==ex_rs;
  - else 00. MEM match wins over WB match.
- Register 0 never triggers a hazard or a forward.
- Reset asserted mid-stall or mid-halt: state returns to RUN and halt clears immediately (asynchronously).

Optional Feature:
HAZARD_STALL_CNT_EN. When defined, the block adds three CNT_W-bit counters, reset to 0:
- cnt_mem: cycles with rule 1 active.
- cnt_lu: cycles with rule 4 active.
- cnt_if: cycles with rule 5 active.

Counter rules:
- Each counter saturates at all-ones and freezes in HALTED.
- Output ports: cnt_mem, cnt_lu, cnt_if, each out, CNT_W.

When undefined, no counters or ports exist; behaviour is otherwise identical.

Test Plan:
- Reset, then ihit=1, no hazards -> state=00, pc_en=1, all enables 1, flushes 0, fwd=00, halt=0.
- LW to r5 in EX; ID uses rs=5 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle. Next cycle with r5 in MEM and ex_rs=5 -> fwd_a=01.
- mem_dmemop=1, dhit=0 for 3 cycles, then dhit=1 with ihit=0 -> 3 cycles all en=0, state=01. Dhit cycle: state returns 00, pc_en=0, ifid_flush=1, memwb_en=1.
- redirect=1 with ihit=0, BRANCH_STAGE=1 -> pc_en=1, ifid_flush=1, idex_flush=1, exmem_flush=0. With BRANCH_STAGE=2 -> exmem_flush=1.
- mem_halt=1 with redirect=1 -> flushes applied, pc_en=0. Next cycle halt=1, state=10, imemREN=0; holds 10 cycles; nRST low clears halt.
- With HAZARD_STALL_CNT_EN and CNT_W=4: 20 mem-stall cycles -> cnt_mem=15 (saturated).
